// File: rtl/lbdr_dr.sv
// LBDR routing unit with deroute, packet-sticky port requests and flit-protocol checks.
// Ports: clk/rst, empty, flit_id, dst_addr, *_rst config inputs, N/E/W/S/Lport, deroute, route_err, proto_err, busy.
module lbdr_dr #(
  parameter int COORD_W = 2,
  parameter bit DR_EN   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 empty,
  input  logic [2:0]           flit_id,
  input  logic [2*COORD_W-1:0] dst_addr,
  input  logic [2*COORD_W-1:0] cur_addr_rst,
  input  logic [7:0]           Rxy_rst,
  input  logic [3:0]           Cx_rst,
  input  logic [7:0]           dr_rst,
  output logic                 Nport,
  output logic                 Eport,
  output logic                 Wport,
  output logic                 Sport,
  output logic                 Lport,
  output logic                 deroute,
  output logic                 route_err,
  output logic                 proto_err,
  output logic                 busy
);

  localparam int AW = 2 * COORD_W;

  typedef enum logic {IDLE, ACTIVE} state_t;

  logic [AW-1:0] cur_q;
  logic [7:0]    rxy_q;
  logic [3:0]    cx_q;
  logic [7:0]    dr_q;

  state_t        state_q;
  logic [4:0]    port_q;
  logic          der_q;
  logic          rerr_q;
  logic          perr_q;
  logic          busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q <= cur_addr_rst;
      rxy_q <= Rxy_rst;
      cx_q  <= Cx_rst;
      dr_q  <= dr_rst;
    end
  end

  logic [COORD_W-1:0] yc, xc, yd, xd;
  logic n1, s1, e1, w1;
  logic mn, me, mw, ms, loc;

  assign yc = cur_q[AW-1:COORD_W];
  assign xc = cur_q[COORD_W-1:0];
  assign yd = dst_addr[AW-1:COORD_W];
  assign xd = dst_addr[COORD_W-1:0];

  assign n1 = yd < yc;
  assign s1 = yc < yd;
  assign e1 = xc < xd;
  assign w1 = xd < xc;

  assign mn = ((n1 & ~e1 & ~w1) | (n1 & e1 & rxy_q[0])
             | (n1 & w1 & rxy_q[1])) & cx_q[0];
  assign me = ((e1 & ~n1 & ~s1) | (e1 & n1 & rxy_q[2])
             | (e1 & s1 & rxy_q[3])) & cx_q[1];
  assign mw = ((w1 & ~n1 & ~s1) | (w1 & n1 & rxy_q[4])
             | (w1 & s1 & rxy_q[5])) & cx_q[2];
  assign ms = ((s1 & ~e1 & ~w1) | (s1 & e1 & rxy_q[6])
             | (s1 & w1 & rxy_q[7])) & cx_q[3];
  assign loc = (dst_addr == cur_q);

  // Port index order is N=0, E=1, W=2, S=3, L=4 so that a deroute
  // code selects both its Cx bit and its output bit directly.
  logic [1:0] pdir;
  logic [1:0] code;
  logic [3:0] dr_oh;
  logic [4:0] rt_ports;
  logic       rt_der;
  logic       rt_err;

  always_comb begin
    pdir     = n1 ? 2'd0 : s1 ? 2'd3 : e1 ? 2'd1 : 2'd2;
    code     = 2'd0;
    case (pdir)
      2'd0:    code = dr_q[1:0];
      2'd1:    code = dr_q[3:2];
      2'd2:    code = dr_q[5:4];
      default: code = dr_q[7:6];
    endcase
    dr_oh    = 4'b0001 << code;
    rt_ports = 5'b0;
    rt_der   = 1'b0;
    rt_err   = 1'b0;
    if (loc) begin
      rt_ports = 5'b10000;
    end else if (mn | me | mw | ms) begin
      rt_ports = {1'b0, ms, mw, me, mn};
    end else if (DR_EN && cx_q[code]) begin
      rt_ports = {1'b0, dr_oh};
      rt_der   = 1'b1;
    end else begin
      rt_err   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      port_q  <= 5'b0;
      der_q   <= 1'b0;
      rerr_q  <= 1'b0;
      perr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rerr_q <= 1'b0;
      perr_q <= 1'b0;
      // A single-flit packet only owns the ports for one cycle.
      if (state_q == IDLE) begin
        port_q <= 5'b0;
        der_q  <= 1'b0;
      end
      if (!empty) begin
        case (flit_id)
          3'b001: begin
            perr_q  <= (state_q == ACTIVE);
            port_q  <= rt_ports;
            der_q   <= rt_der;
            rerr_q  <= rt_err;
            state_q <= ACTIVE;
            busy_q  <= 1'b1;
          end
          3'b101: begin
            perr_q  <= (state_q == ACTIVE);
            port_q  <= rt_ports;
            der_q   <= rt_der;
            rerr_q  <= rt_err;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          3'b010: begin
            perr_q <= (state_q == IDLE);
          end
          3'b100: begin
            if (state_q == IDLE) begin
              perr_q <= 1'b1;
            end else begin
              port_q  <= 5'b0;
              der_q   <= 1'b0;
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            perr_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign Nport     = port_q[0];
  assign Eport     = port_q[1];
  assign Wport     = port_q[2];
  assign Sport     = port_q[3];
  assign Lport     = port_q[4];
  assign deroute   = der_q;
  assign route_err = rerr_q;
  assign proto_err = perr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lbdr_dr.sv
// Testbench for lbdr_dr: directed scenarios plus random traffic,
// two instances (deroute enabled / disabled) checked against a model.
module tb_lbdr_dr;

  localparam int CW = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       empty;
  logic [2:0] flit_id;
  logic [3:0] dst_addr;
  logic [3:0] cur_addr_rst;
  logic [7:0] Rxy_rst;
  logic [3:0] Cx_rst;
  logic [7:0] dr_rst;

  logic n0, e0, w0, s0, l0, d0, re0, pe0, b0;
  logic n1, e1, w1, s1, l1, d1, re1, pe1, b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lbdr_dr #(.COORD_W(CW), .DR_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .empty(empty), .flit_id(flit_id),
    .dst_addr(dst_addr), .cur_addr_rst(cur_addr_rst),
    .Rxy_rst(Rxy_rst), .Cx_rst(Cx_rst), .dr_rst(dr_rst),
    .Nport(n0), .Eport(e0), .Wport(w0), .Sport(s0), .Lport(l0),
    .deroute(d0), .route_err(re0), .proto_err(pe0), .busy(b0)
  );

  lbdr_dr #(.COORD_W(CW), .DR_EN(1'b0)) u1 (
    .clk(clk), .rst(rst), .empty(empty), .flit_id(flit_id),
    .dst_addr(dst_addr), .cur_addr_rst(cur_addr_rst),
    .Rxy_rst(Rxy_rst), .Cx_rst(Cx_rst), .dr_rst(dr_rst),
    .Nport(n1), .Eport(e1), .Wport(w1), .Sport(s1), .Lport(l1),
    .deroute(d1), .route_err(re1), .proto_err(pe1), .busy(b1)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [4:0] p;
    logic       der;
    logic       err;
  } rt_t;

  int   m_cur, m_rxy, m_cx, m_dr;
  bit   started = 0;
  bit   m_act [2];
  rt_t  m_rt  [2];
  bit   m_perr[2];

  function automatic rt_t mroute(input bit dren, input int dst);
    rt_t r;
    int yc, xc, yd, xd, dy, dx, prim, code;
    bit gn, ge, gw, gs;
    r  = '0;
    yc = m_cur / 4; xc = m_cur % 4;
    yd = dst / 4;   xd = dst % 4;
    dy = yd - yc;   dx = xd - xc;
    if (dst == m_cur) begin
      r.p[4] = 1'b1;
      return r;
    end
    gn = dy < 0 && (dx == 0 || (dx > 0 && m_rxy[0]) || (dx < 0 && m_rxy[1]));
    ge = dx > 0 && (dy == 0 || (dy < 0 && m_rxy[2]) || (dy > 0 && m_rxy[3]));
    gw = dx < 0 && (dy == 0 || (dy < 0 && m_rxy[4]) || (dy > 0 && m_rxy[5]));
    gs = dy > 0 && (dx == 0 || (dx > 0 && m_rxy[6]) || (dx < 0 && m_rxy[7]));
    r.p[0] = gn && m_cx[0];
    r.p[1] = ge && m_cx[1];
    r.p[2] = gw && m_cx[2];
    r.p[3] = gs && m_cx[3];
    if (r.p[3:0] != 4'b0) return r;
    prim = (dy < 0) ? 0 : (dy > 0) ? 3 : (dx > 0) ? 1 : 2;
    code = (m_dr >> (2 * prim)) & 3;
    if (dren && m_cx[code]) begin
      r.p[code] = 1'b1;
      r.der     = 1'b1;
    end else begin
      r.err = 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      started = 1;
      m_cur = cur_addr_rst; m_rxy = Rxy_rst;
      m_cx  = Cx_rst;       m_dr  = dr_rst;
      for (int k = 0; k < 2; k++) begin
        m_act[k] = 0; m_rt[k] = '0; m_perr[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        rt_t r;
        r = mroute(k == 0, dst_addr);
        m_perr[k]  = 0;
        m_rt[k].err = 1'b0;
        if (!m_act[k]) begin
          m_rt[k].p = '0; m_rt[k].der = 1'b0;
        end
        if (!empty) begin
          if (flit_id == 3'b001 || flit_id == 3'b101) begin
            m_perr[k] = m_act[k];
            m_rt[k]   = r;
            m_act[k]  = (flit_id == 3'b001);
          end else if (flit_id == 3'b010) begin
            m_perr[k] = !m_act[k];
          end else if (flit_id == 3'b100) begin
            if (!m_act[k]) m_perr[k] = 1;
            else begin
              m_rt[k].p = '0; m_rt[k].der = 1'b0; m_act[k] = 0;
            end
          end else begin
            m_perr[k] = 1;
          end
        end
      end
    end
  end

  function automatic logic [8:0] mvec(input int k);
    return {m_rt[k].p, m_rt[k].der, m_rt[k].err, m_perr[k], m_act[k]};
  endfunction

  wire [8:0] dv0 = {l0, s0, w0, e0, n0, d0, re0, pe0, b0};
  wire [8:0] dv1 = {l1, s1, w1, e1, n1, d1, re1, pe1, b1};

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (dv0 !== mvec(0)) begin
        errors++;
        $display("FAIL cyc_dr1 t=%0t got %b want %b", $time, dv0, mvec(0));
      end
      checks++;
      if (dv1 !== mvec(1)) begin
        errors++;
        $display("FAIL cyc_dr0 t=%0t got %b want %b", $time, dv1, mvec(1));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pin(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic [2:0] f, input logic [3:0] d);
    empty = e; flit_id = f; dst_addr = d;
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [3:0] cur, input logic [7:0] rxy,
                     input logic [3:0] cx, input logic [7:0] dr);
    cur_addr_rst = cur; Rxy_rst = rxy; Cx_rst = cx; dr_rst = dr;
    rst = 1'b1;
    step(1'b1, 3'b000, 4'd0);
    step(1'b1, 3'b000, 4'd0);
    rst = 1'b0;
  endtask

  localparam logic [2:0] H = 3'b001, B = 3'b010, T = 3'b100, SF = 3'b101;

  initial begin
    rst = 1'b1; empty = 1'b1; flit_id = 3'b000; dst_addr = 4'd0;
    cur_addr_rst = 4'd5; Rxy_rst = 8'h3C; Cx_rst = 4'hF; dr_rst = 8'h00;

    // Basic E route held across bubbles until tail
    cfg(4'd5, 8'h3C, 4'hF, 8'h00);
    pin("rst_busy", b0, 1'b0);
    pin("rst_eport", e0, 1'b0);
    step(1'b0, H, 4'd6);
    pin("hdr_eport", e0, 1'b1);
    pin("hdr_busy", b0, 1'b1);
    pin("hdr_nport", n0, 1'b0);
    step(1'b1, T, 4'd0);
    pin("bubble_eport", e0, 1'b1);
    step(1'b0, B, 4'd0);
    step(1'b1, B, 4'd0);
    step(1'b0, B, 4'd0);
    pin("body_eport", e0, 1'b1);
    step(1'b0, T, 4'd0);
    pin("tail_eport", e0, 1'b0);
    pin("tail_busy", b0, 1'b0);

    // Diagonal NE: Rne=0 then Rne=1
    step(1'b0, H, 4'd2);
    pin("ne_eport", e0, 1'b1);
    pin("ne_nport", n0, 1'b0);
    step(1'b0, T, 4'd0);
    cfg(4'd5, 8'h3D, 4'hF, 8'h00);
    step(1'b0, H, 4'd2);
    pin("ne2_nport", n0, 1'b1);
    pin("ne2_eport", e0, 1'b1);
    step(1'b0, T, 4'd0);

    // East link down: deroute to N, or route error without deroute
    cfg(4'd5, 8'h3C, 4'b1101, 8'h00);
    step(1'b0, H, 4'd6);
    pin("dr_nport", n0, 1'b1);
    pin("dr_flag", d0, 1'b1);
    pin("nodr_nport", n1, 1'b0);
    pin("nodr_rerr", re1, 1'b1);
    step(1'b0, B, 4'd0);
    pin("nodr_rerr_pulse", re1, 1'b0);
    pin("nodr_busy", b1, 1'b1);
    step(1'b0, T, 4'd0);

    // Single-flit local packet
    cfg(4'd5, 8'h3C, 4'hF, 8'h00);
    step(1'b0, SF, 4'd5);
    pin("sf_lport", l0, 1'b1);
    pin("sf_busy", b0, 1'b0);
    step(1'b1, 3'b000, 4'd0);
    pin("sf_lport_drop", l0, 1'b0);

    // Missing tail, then tail while idle
    step(1'b0, H, 4'd6);
    step(1'b0, H, 4'd4);
    pin("mt_perr", pe0, 1'b1);
    pin("mt_wport", w0, 1'b1);
    pin("mt_eport", e0, 1'b0);
    step(1'b0, T, 4'd0);
    step(1'b0, T, 4'd0);
    pin("idle_tail_perr", pe0, 1'b1);
    pin("idle_tail_wport", w0, 1'b0);

    // Reset mid-packet with new connectivity, S link now gone
    step(1'b0, H, 4'd6);
    pin("pre_rst_eport", e0, 1'b1);
    cur_addr_rst = 4'd5; Rxy_rst = 8'h3C; Cx_rst = 4'h7; dr_rst = 8'hC0;
    rst = 1'b1;
    step(1'b0, H, 4'd6);
    pin("rst_mid_eport", e0, 1'b0);
    pin("rst_mid_busy", b0, 1'b0);
    rst = 1'b0;
    step(1'b0, H, 4'd13);
    pin("s_down_sport", s0, 1'b0);
    pin("s_down_rerr", re0, 1'b1);
    step(1'b0, T, 4'd0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      logic [2:0] f;
      int sel;
      if ($urandom_range(0, 299) == 0) begin
        cur_addr_rst = 4'($urandom); Rxy_rst = 8'($urandom);
        Cx_rst = 4'($urandom); dr_rst = 8'($urandom);
        rst = 1'b1;
      end else begin
        rst = 1'b0;
      end
      sel = $urandom_range(0, 19);
      if (sel < 5)       f = H;
      else if (sel < 11) f = B;
      else if (sel < 16) f = T;
      else if (sel < 19) f = SF;
      else               f = 3'($urandom);
      step(($urandom_range(0, 3) == 0), f, 4'($urandom));
    end
    rst = 1'b0;
    step(1'b1, 3'b000, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
